// File: rtl/duty_ramp_gen.sv
// -----------------------------------------------------------------------------
// duty_ramp_gen
//   Duty-cycle source for an 8-bit PWM stage. A target duty is accepted over a
//   valid/ready handshake and the output walks toward it by a fixed step every
//   'rate' clock cycles (soft fade). While breathe_en_i is held high in IDLE the
//   output sweeps a continuous triangle 0..MAX..0. The PWM stage samples
//   dutycycle_o at the start of its own period, so every change shows up on the
//   next PWM period.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   rst             asynchronous, active-high reset
//   target_i        requested duty cycle
//   rate_i          clock cycles per step tick (0 behaves as 1)
//   step_i          duty increment per tick (0 behaves as 1)
//   target_valid_i  target/rate/step are valid this cycle
//   target_ready_o  high in IDLE: a request will be accepted
//   breathe_en_i    level: run the triangle sweep while high
//   dutycycle_o     registered duty cycle to the PWM stage
//   busy_o          high whenever the block is not IDLE
//   done_o          one-cycle pulse when a ramp lands on its target
// -----------------------------------------------------------------------------
module duty_ramp_gen #(
    parameter int WIDTH  = 8,
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  target_i,
    input  logic [RATE_W-1:0] rate_i,
    input  logic [WIDTH-1:0]  step_i,
    input  logic              target_valid_i,
    output logic              target_ready_o,
    input  logic              breathe_en_i,
    output logic [WIDTH-1:0]  dutycycle_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [WIDTH-1:0]  DUTY_MAX = '1;
    localparam logic [WIDTH-1:0]  STEP_ONE = WIDTH'(1);
    localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        BR_UP = 2'd2,
        BR_DN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    duty_q,  duty_d;
    logic [WIDTH-1:0]    tgt_q,   tgt_d;
    logic [WIDTH-1:0]    step_q,  step_d;
    logic [RATE_W-1:0]   rate_q,  rate_d;
    logic [RATE_W-1:0]   cnt_q,   cnt_d;
    logic                done_q,  done_d;

    logic                accept;
    logic                tick;
    logic [RATE_W-1:0]   rate_last;
    logic [WIDTH-1:0]    step_use;
    logic [WIDTH-1:0]    ramp_next;
    logic [WIDTH:0]      br_sum;
    logic [WIDTH-1:0]    br_up_next;
    logic [WIDTH-1:0]    br_dn_next;

    assign accept = target_valid_i && (state_q == IDLE);

    // The latched rate/step are only zero straight out of reset (an accept
    // forces zeros to 1); breathe can run before any accept, so guard here too.
    assign rate_last = (rate_q == '0) ? '0 : rate_q - RATE_ONE;
    assign step_use  = (step_q == '0) ? STEP_ONE : step_q;
    assign tick      = (cnt_q == rate_last);

    // Ramp step toward the target, clamped so it lands exactly on it.
    always_comb begin
        ramp_next = duty_q;
        if (duty_q < tgt_q) begin
            if ((tgt_q - duty_q) <= step_use) ramp_next = tgt_q;
            else                              ramp_next = duty_q + step_use;
        end else if (duty_q > tgt_q) begin
            if ((duty_q - tgt_q) <= step_use) ramp_next = tgt_q;
            else                              ramp_next = duty_q - step_use;
        end
    end

    // Breathe steps saturate at the rails; the extra sum bit catches overflow.
    assign br_sum     = {1'b0, duty_q} + {1'b0, step_use};
    assign br_up_next = br_sum[WIDTH] ? DUTY_MAX : br_sum[WIDTH-1:0];
    assign br_dn_next = (duty_q <= step_use) ? '0 : duty_q - step_use;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        rate_d  = rate_q;
        cnt_d   = tick ? '0 : cnt_q + RATE_ONE;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (accept) begin
                    tgt_d  = target_i;
                    step_d = (step_i == '0) ? STEP_ONE : step_i;
                    rate_d = (rate_i == '0) ? RATE_ONE : rate_i;
                    if (target_i == duty_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                        cnt_d   = '0;
                    end
                end else if (breathe_en_i) begin
                    state_d = BR_UP;
                    cnt_d   = '0;
                end
            end

            RAMP: begin
                if (tick) begin
                    duty_d = ramp_next;
                    if (ramp_next == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            BR_UP: begin
                if (!breathe_en_i) begin
                    state_d = IDLE;
                end else if (tick) begin
                    duty_d = br_up_next;
                    if (br_up_next == DUTY_MAX) state_d = BR_DN;
                end
            end

            BR_DN: begin
                if (!breathe_en_i) begin
                    state_d = IDLE;
                end else if (tick) begin
                    duty_d = br_dn_next;
                    if (br_dn_next == '0) state_d = BR_UP;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            rate_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign target_ready_o = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign dutycycle_o    = duty_q;
    assign done_o         = done_q;

endmodule
